// File: rtl/restador_serial.sv
// Bit-serial subtractor/adder: one bit per clock, LSB first, with a final
// fix-up cycle producing magnitude, wrap, signed-difference or sum results.
module restador_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic [WIDTH-1:0] resta,
  output logic             neg,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, raw_q, resta_q;
  logic [1:0]       mode_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q, neg_q, cout_q, ovf_q, busy_q, done_q;

  logic             a_bit_s, b_bit_s, bit_d, c_d;
  logic [WIDTH-1:0] resta_d;
  logic             neg_d, cout_d, ovf_d;
  logic             a_msb_s, b_msb_s, r_msb_s;

  // One-bit full subtractor, or full adder in mode 11, on the current bit.
  always_comb begin
    a_bit_s = a_q[cnt_q];
    b_bit_s = b_q[cnt_q];
    bit_d   = a_bit_s ^ b_bit_s ^ c_q;
    if (mode_q == 2'b11) begin
      c_d = (a_bit_s & b_bit_s) | (c_q & (a_bit_s ^ b_bit_s));
    end else begin
      c_d = (~a_bit_s & b_bit_s) | (~(a_bit_s ^ b_bit_s) & c_q);
    end
  end

  // Result fix-up applied once the raw result and final carry/borrow are complete.
  always_comb begin
    a_msb_s = a_q[WIDTH-1];
    b_msb_s = b_q[WIDTH-1];
    r_msb_s = raw_q[WIDTH-1];
    resta_d = raw_q;
    neg_d   = 1'b0;
    cout_d  = c_q;
    ovf_d   = 1'b0;
    case (mode_q)
      2'b00: begin
        if (c_q) begin
          resta_d = (~raw_q) + WIDTH'(1'b1);
          neg_d   = 1'b1;
        end else begin
          resta_d = raw_q;
          neg_d   = 1'b0;
        end
      end
      2'b01: begin
        resta_d = raw_q;
      end
      2'b10: begin
        ovf_d = (a_msb_s != b_msb_s) && (r_msb_s != a_msb_s);
        neg_d = r_msb_s ^ ovf_d;
      end
      2'b11: begin
        ovf_d = (a_msb_s == b_msb_s) && (r_msb_s != a_msb_s);
        neg_d = r_msb_s ^ ovf_d;
      end
      default: begin
        resta_d = raw_q;
      end
    endcase
  end

  // Control FSM with datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      raw_q   <= '0;
      mode_q  <= 2'b00;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      resta_q <= '0;
      neg_q   <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (init) begin
            a_q     <= portA;
            b_q     <= portB;
            mode_q  <= mode;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          // Shift in from the top so bit 0 lands at position 0 after WIDTH steps.
          raw_q <= {bit_d, raw_q[WIDTH-1:1]};
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          resta_q <= resta_d;
          neg_q   <= neg_d;
          cout_q  <= cout_d;
          ovf_q   <= ovf_d;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign resta = resta_q;
  assign neg   = neg_q;
  assign cout  = cout_q;
  assign ovf   = ovf_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule
